// File: rtl/spi_reg_controller.sv
// SPI mode-0 initiator for the 16-bit write-only register bus: one LSB-first frame {data, addr, 1} per request.
// Define SPI_REG_CONTROLLER_QUEUE_EN to add a 2-entry request FIFO in front of the frame FSM.
module spi_reg_controller #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       sclk,
    output logic       copi,
    output logic       ncs,
    output logic       busy,
    output logic       done
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(CS_GAP);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP} state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [3:0]         bit_q, bit_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [15:0]        shift_q, shift_d;
    logic               sclk_q, sclk_d;
    logic               copi_q, copi_d;
    logic               ncs_q, ncs_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               start;
    logic [15:0]        start_word;
    logic               div_last;

    assign div_last = (div_q == DIV_W'(CLK_DIV - 1));

    // Output registers are computed from next state so pins change on the same edge as the FSM.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        shift_d = shift_q;
        sclk_d  = sclk_q;
        copi_d  = copi_q;
        ncs_d   = ncs_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETUP;
                    shift_d = start_word;
                    copi_d  = start_word[0];
                    ncs_d   = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            S_SETUP: begin
                div_d = div_q + DIV_W'(1);
                if (div_last) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                div_d = div_q + DIV_W'(1);
                if (div_last) begin
                    div_d = '0;
                    if (sclk_q) begin
                        sclk_d  = 1'b0;
                        copi_d  = shift_q[1];
                        shift_d = {1'b0, shift_q[15:1]};
                    end else if (bit_q == 4'd15) begin
                        state_d = S_GAP;
                        ncs_d   = 1'b1;
                        copi_d  = 1'b0;
                        gap_d   = '0;
                    end else begin
                        sclk_d = 1'b1;
                        bit_d  = bit_q + 4'd1;
                    end
                end
            end
            S_GAP: begin
                gap_d = gap_q + GAP_W'(1);
                if (gap_q == GAP_W'(CS_GAP - 2)) done_d = 1'b1;
                if (gap_q == GAP_W'(CS_GAP - 1)) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            shift_q <= '0;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            ncs_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            shift_q <= shift_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            ncs_q   <= ncs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef SPI_REG_CONTROLLER_QUEUE_EN
    logic [15:0] fifo_mem [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  cnt_q;
    logic        push, pop;

    assign req_ready  = (cnt_q != 2'd2);
    assign push       = req_valid && req_ready;
    assign pop        = (state_q == S_IDLE) && (cnt_q != 2'd0);
    assign start      = pop;
    assign start_word = fifo_mem[rd_ptr_q];

    // NOTE: FIFO storage has no reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {req_data, req_addr, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
`else
    logic ready_q, ready_d;

    assign ready_d    = (state_d == S_IDLE);
    assign req_ready  = ready_q;
    assign start      = (state_q == S_IDLE) && req_valid && ready_q;
    assign start_word = {req_data, req_addr, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ready_q <= 1'b1;
        else     ready_q <= ready_d;
    end
`endif

    assign sclk = sclk_q;
    assign copi = copi_q;
    assign ncs  = ncs_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_spi_reg_controller.sv
// Scoreboard bench for spi_reg_controller: the driver queues expected frames, a pin monitor decodes
// SPI frames into a small peripheral register model and checks each one when done pulses.
module tb_spi_reg_controller;
    localparam int CLK_DIV = 4;
    localparam int CS_GAP  = 4;

    typedef struct {
        logic [15:0] word;
        int          t0;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       sclk, copi, ncs, busy, done;
    logic       v6, r6, sclk6, copi6, ncs6, busy6, done6;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    exp_t        exp_q[$];
    int          gaps[$];
    logic [7:0]  periph [5];

    // monitor state
    logic        prev_ncs = 1'b1, prev_sclk = 1'b0, in_frame = 1'b0, have_rise = 1'b0;
    logic [15:0] rx_word = '0;
    int          mon_nbits = 0, low_len = 0, run_len = 0, phase_err = 0, ready_err = 0;
    int          fall_t = 0, rise_t = 0, first_rise_t = 0;

    spi_reg_controller #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .sclk(sclk), .copi(copi),
        .ncs(ncs), .busy(busy), .done(done)
    );

    spi_reg_controller #(.CLK_DIV(6), .CS_GAP(CS_GAP)) u_dut6 (
        .clk(clk), .rst(rst), .req_valid(v6), .req_ready(r6),
        .req_addr(req_addr), .req_data(req_data), .sclk(sclk6), .copi(copi6),
        .ncs(ncs6), .busy(busy6), .done(done6)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with req_valid still high.
    task automatic send(input logic [6:0] a, input logic [7:0] d, input logic [15:0] w, output int t0);
        int n;
        req_addr  = a;
        req_data  = d;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("accept_within_budget", 32'(req_ready), 1);
        t0 = cyc + 1;
        exp_q.push_back('{word: w, t0: t0});
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        req_valid = 1'b0;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_within_budget", 32'(exp_q.size()), 0);
    endtask

    // Pin monitor and scoreboard.
    initial forever begin
        int t;
        @(negedge clk);
        if (rst) begin
            in_frame  = 1'b0;
            prev_ncs  = 1'b1;
            prev_sclk = 1'b0;
            ready_err = 0;
        end else begin
            t = cyc + 1;
            if (prev_ncs && !ncs) begin
                in_frame = 1'b1; fall_t = t; mon_nbits = 0; low_len = 0;
                run_len = 0; phase_err = 0; first_rise_t = 0; rx_word = '0;
                if (have_rise) gaps.push_back(t - rise_t);
            end
            if (in_frame && !ncs) begin
                low_len++;
                if (sclk == prev_sclk || low_len == 1) run_len++;
                else begin
                    if (run_len != CLK_DIV) phase_err++;
                    run_len = 1;
                end
                if (!prev_sclk && sclk) begin
                    if (mon_nbits < 16) rx_word[mon_nbits] = copi;
                    if (mon_nbits == 0) first_rise_t = t;
                    mon_nbits++;
                end
            end
            if (in_frame && !prev_ncs && ncs) begin
                in_frame  = 1'b0;
                rise_t    = t;
                have_rise = 1'b1;
                if (run_len != CLK_DIV) phase_err++;
                if (mon_nbits == 16 && rx_word[0] && rx_word[7:1] < 7'd5)
                    periph[int'(rx_word[7:1])] = rx_word[15:8];
            end
`ifndef SPI_REG_CONTROLLER_QUEUE_EN
            if (busy && req_ready) ready_err++;
`endif
            if (done) begin
                check("done_has_pending_request", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("frame_word", rx_word, e.word);
                    check("frame_bits", mon_nbits, 16);
                    check("ncs_low_cycles", low_len, 33 * CLK_DIV);
                    check("sclk_half_period_errors", phase_err, 0);
                    check("first_rise_after_ncs_fall", first_rise_t - fall_t, CLK_DIV);
                    check("done_after_ncs_fall", t - fall_t, 33 * CLK_DIV + CS_GAP - 1);
`ifndef SPI_REG_CONTROLLER_QUEUE_EN
                    check("ncs_fall_time", fall_t, e.t0 + 1);
                    check("done_time", t, e.t0 + 33 * CLK_DIV + CS_GAP);
                    check("ready_low_while_busy", ready_err, 0);
                    ready_err = 0;
`endif
                end
            end
            prev_ncs  = ncs;
            prev_sclk = sclk;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, ta, tb, n;
        logic [6:0]  addrs [5] = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04};
        logic [7:0]  datas [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic [15:0] words [5] = '{16'h1101, 16'h2203, 16'h3305, 16'h4407, 16'h5509};

        rst = 1'b1; req_valid = 1'b0; v6 = 1'b0; req_addr = '0; req_data = '0;
        for (int i = 0; i < 5; i++) periph[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_sclk", sclk, 0);
        check("reset_copi", copi, 0);
        check("reset_ncs", ncs, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_req_ready", req_ready, 1);
        #1 rst = 1'b0;
        @(negedge clk);

        // single write: duty-cycle register
        send(7'h04, 8'hA5, 16'hA509, t0);
        wait_idle();
        check("pwm_duty_cycle", periph[4], 8'hA5);

        // one write to each defined register
        for (int i = 0; i < 5; i++) begin
            send(addrs[i], datas[i], words[i], t0);
            req_valid = 1'b0;
            @(negedge clk);
        end
        wait_idle();
        for (int i = 0; i < 5; i++) check($sformatf("periph_reg_%0d", i), periph[i], datas[i]);

`ifndef SPI_REG_CONTROLLER_QUEUE_EN
        // second request held valid while busy
        send(7'h02, 8'h3C, 16'h3C05, ta);
        send(7'h01, 8'hF0, 16'hF003, tb);
        wait_idle();
        check("held_request_accept_delay", tb - ta, 33 * CLK_DIV + CS_GAP + 1);
        check("en_reg_out_15_8", periph[1], 8'hF0);
`else
        // three requests on consecutive cycles through the FIFO
        gaps.delete();
        send(7'h02, 8'h0F, 16'h0F05, ta);
        send(7'h03, 8'hF0, 16'hF007, tb);
        send(7'h04, 8'h80, 16'h8009, t0);
        wait_idle();
        check("queued_frame_count", gaps.size(), 3);
        if (gaps.size() == 3) begin
            check("gap_frame_1_2", gaps[1], CS_GAP + 1);
            check("gap_frame_2_3", gaps[2], CS_GAP + 1);
        end
        check("queued_reg_3", periph[3], 8'hF0);
`endif

        // reset in the middle of a frame to register 0
        send(7'h00, 8'hFF, 16'hFF01, t0);
        req_valid = 1'b0;
        n = 0;
        while (!(in_frame && mon_nbits >= 7) && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reached_7th_rise", mon_nbits, 7);
        rst = 1'b1;
        #1;
        check("async_reset_ncs", ncs, 1);
        check("async_reset_sclk", sclk, 0);
        check("async_reset_done", done, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("en_reg_out_7_0_kept", periph[0], 8'h11);
        send(7'h00, 8'h5A, 16'h5A01, t0);
        wait_idle();
        check("en_reg_out_7_0_after_reset", periph[0], 8'h5A);

        // CLK_DIV=6 instance: phase lengths and frame length
        begin
            int lo, bad, run, nb, dn;
            logic ps, fell, closed;
            logic [15:0] w6;
            lo = 0; bad = 0; run = 0; nb = 0; dn = 0; ps = 1'b0; fell = 1'b0; closed = 1'b0; w6 = '0;
            req_addr = 7'h03; req_data = 8'h44; v6 = 1'b1;
            n = 0;
            while (!r6 && n < 100) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
            v6 = 1'b0;
            for (int i = 0; i < 400; i++) begin
                if (!ncs6) begin
                    fell = 1'b1;
                    lo++;
                    if (sclk6 == ps) run++;
                    else begin
                        if (run != 6) bad++;
                        run = 1;
                    end
                    if (!ps && sclk6) begin
                        if (nb < 16) w6[nb] = copi6;
                        nb++;
                    end
                end else if (fell && !closed) begin
                    closed = 1'b1;
                    if (run != 6) bad++;
                end
                if (done6) dn++;
                ps = sclk6;
                @(negedge clk);
            end
            check("div6_ncs_low_cycles", lo, 198);
            check("div6_half_period_errors", bad, 0);
            check("div6_frame_bits", nb, 16);
            check("div6_frame_word", w6, 16'h4407);
            check("div6_done_pulses", dn, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
